// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared widths and types for the register-file writeback scheduler.
package regfile_wb_scheduler_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t REG_X0 = '0;

    // Which requester owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        WB_NONE = 2'b00,
        WB_ALU  = 2'b01,
        WB_LSU  = 2'b10
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_scheduler_wb_arbiter.sv
// Two-source writeback arbiter: LSU normally wins, ALU wins once it has
// been denied STARVE_LIMIT consecutive cycles.
module regfile_wb_scheduler_wb_arbiter
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    alu_valid,
    input  logic    lsu_valid,
    output logic    alu_grant,
    output logic    lsu_grant,
    output wb_src_e grant_src
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;
    logic          alu_first;

    // Grants are suppressed while reset is held so nothing is consumed.
    always_comb begin
        alu_first = (starve_cnt == STARVE_MAX);
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        grant_src = WB_NONE;
        if (reset_n) begin
            if (alu_valid && (!lsu_valid || alu_first)) begin
                alu_grant = 1'b1;
                grant_src = WB_ALU;
            end else if (lsu_valid) begin
                lsu_grant = 1'b1;
                grant_src = WB_LSU;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!alu_valid || alu_grant) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler in front of the register file's single write port,
// with a load scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_PENDING  = 8
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      issue_valid,
    input  reg_addr_t issue_rs1,
    input  reg_addr_t issue_rs2,
    input  reg_addr_t issue_rd,
    input  logic      issue_long,
    output logic      issue_stall,
    input  logic      alu_wb_valid,
    input  reg_addr_t alu_wb_addr,
    input  xlen_t     alu_wb_data,
    output logic      alu_wb_ready,
    input  logic      lsu_wb_valid,
    input  reg_addr_t lsu_wb_addr,
    input  xlen_t     lsu_wb_data,
    output logic      lsu_wb_ready,
    output logic      reg_wren,
    output reg_addr_t write_address,
    output xlen_t     write_data,
    output logic      wb_error
);

    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [PW-1:0]       pend_cnt;
    logic                alu_grant;
    logic                lsu_grant;
    wb_src_e             grant_src;
    logic                pend_full;
    logic                hazard;
    logic                load_issue;

    // Handshake: a source transfers in the cycle where valid && ready; ready
    // is combinational, goes only to the granted source, and must not be
    // waited on by valid (valid may not depend on ready).
    regfile_wb_scheduler_wb_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .alu_valid(alu_wb_valid),
        .lsu_valid(lsu_wb_valid),
        .alu_grant(alu_grant),
        .lsu_grant(lsu_grant),
        .grant_src(grant_src)
    );

    assign alu_wb_ready = alu_grant;
    assign lsu_wb_ready = lsu_grant;

    always_comb begin
        write_address = lsu_wb_addr;
        write_data    = lsu_wb_data;
        if (grant_src == WB_ALU) begin
            write_address = alu_wb_addr;
            write_data    = alu_wb_data;
        end
        reg_wren = (grant_src != WB_NONE) && (write_address != REG_X0);
    end

    // Registered busy only: a cleared register unstalls one cycle later.
    assign pend_full   = (pend_cnt == PEND_MAX);
    assign hazard      = busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]
                       | (issue_long & pend_full);
    assign issue_stall = !reset_n | (issue_valid & hazard);
    assign load_issue  = issue_valid & !issue_stall & issue_long;

    always_comb begin
        busy_nxt = busy;
        if (load_issue && issue_rd != REG_X0) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        if (lsu_grant) begin
            busy_nxt[lsu_wb_addr] = 1'b0;
        end
        busy_nxt[REG_X0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy     <= '0;
            pend_cnt <= '0;
            wb_error <= 1'b0;
        end else begin
            busy <= busy_nxt;
            // A writeback of a load forgotten by reset must not underflow.
            case ({load_issue, lsu_grant && (pend_cnt != '0)})
                2'b10:   pend_cnt <= pend_cnt + 1'b1;
                2'b01:   pend_cnt <= pend_cnt - 1'b1;
                default: pend_cnt <= pend_cnt;
            endcase
            if (lsu_grant && lsu_wb_addr != REG_X0 && !busy[lsu_wb_addr]) begin
                wb_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus a
// randomized run against a queue-based model of outstanding loads.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rs1 = '0;
  logic [4:0]  issue_rs2 = '0;
  logic [4:0]  issue_rd = '0;
  logic        issue_long = 1'b0;
  logic        issue_stall;
  logic        alu_wb_valid = 1'b0;
  logic [4:0]  alu_wb_addr = '0;
  logic [31:0] alu_wb_data = '0;
  logic        alu_wb_ready;
  logic        lsu_wb_valid = 1'b0;
  logic [4:0]  lsu_wb_addr = '0;
  logic [31:0] lsu_wb_data = '0;
  logic        lsu_wb_ready;
  logic        reg_wren;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic        wb_error;

  int checks = 0;
  int errors = 0;

  // Model: destinations of loads issued and not yet written back.
  int out_q[$];
  int starve_m;

  regfile_wb_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_rd     (issue_rd),
    .issue_long   (issue_long),
    .issue_stall  (issue_stall),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_addr  (alu_wb_addr),
    .alu_wb_data  (alu_wb_data),
    .alu_wb_ready (alu_wb_ready),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_addr  (lsu_wb_addr),
    .lsu_wb_data  (lsu_wb_data),
    .lsu_wb_ready (lsu_wb_ready),
    .reg_wren     (reg_wren),
    .write_address(write_address),
    .write_data   (write_data),
    .wb_error     (wb_error)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    issue_valid  = 1'b0;
    issue_long   = 1'b0;
    issue_rs1    = '0;
    issue_rs2    = '0;
    issue_rd     = '0;
    alu_wb_valid = 1'b0;
    lsu_wb_valid = 1'b0;
  endtask

  task automatic drive_load(input int rd);
    issue_valid = 1'b1;
    issue_long  = 1'b1;
    issue_rs1   = '0;
    issue_rs2   = '0;
    issue_rd    = 5'(rd);
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  function automatic bit in_q(input int x);
    foreach (out_q[i]) if (out_q[i] == x) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd5; alu_wb_data = 32'h1234_5678;
    lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd6; lsu_wb_data = 32'h8765_4321;
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd3;
    for (int c = 0; c < 2; c++) begin
      tick();
      settle();
      checks++; if (reg_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b exp 0", reg_wren); end
      checks++; if (alu_wb_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready got %b exp 0", alu_wb_ready); end
      checks++; if (lsu_wb_ready !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready got %b exp 0", lsu_wb_ready); end
      checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL reset_stall got %b exp 1", issue_stall); end
    end
    tick();
    reset_n = 1'b1;
    idle_inputs();
    // Every register must read as not busy after reset.
    for (int r = 0; r < 32; r++) begin
      issue_valid = 1'b1; issue_long = 1'b0;
      issue_rs1 = 5'(r); issue_rs2 = 5'(r); issue_rd = 5'(r);
      settle();
      checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL reset_busy_clear reg %0d got stall %b exp 0", r, issue_stall); end
      tick();
    end
    idle_inputs();
    settle();
    checks++; if (wb_error !== 1'b0) begin errors++; $display("FAIL reset_wb_error got %b exp 0", wb_error); end
    tick();
  endtask

  task automatic test_alu_only();
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd5; alu_wb_data = 32'hDEADBEEF;
    settle();
    checks++; if (alu_wb_ready !== 1'b1) begin errors++; $display("FAIL alu_only_ready got %b exp 1", alu_wb_ready); end
    checks++; if (lsu_wb_ready !== 1'b0) begin errors++; $display("FAIL alu_only_lsu_ready got %b exp 0", lsu_wb_ready); end
    checks++; if (reg_wren !== 1'b1) begin errors++; $display("FAIL alu_only_wren got %b exp 1", reg_wren); end
    checks++; if (write_address !== 5'd5) begin errors++; $display("FAIL alu_only_addr got %0d exp 5", write_address); end
    checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_only_data got %h exp deadbeef", write_data); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_contention();
    for (int r = 1; r <= 5; r++) begin
      drive_load(r);
      settle();
      checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL contention_load_issue rd %0d got stall %b exp 0", r, issue_stall); end
      tick();
    end
    idle_inputs();
    tick();
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd12; alu_wb_data = 32'hA5A5_A5A5;
    lsu_wb_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      lsu_wb_addr = (c < 4) ? 5'(c + 1) : 5'd5;
      lsu_wb_data = 32'h1000 + 32'(c);
      settle();
      checks++; if (alu_wb_ready !== (c == 4)) begin errors++; $display("FAIL contention_alu_ready cycle %0d got %b exp %b", c, alu_wb_ready, (c == 4)); end
      checks++; if (lsu_wb_ready !== (c != 4)) begin errors++; $display("FAIL contention_lsu_ready cycle %0d got %b exp %b", c, lsu_wb_ready, (c != 4)); end
      checks++; if (write_address !== ((c == 4) ? 5'd12 : lsu_wb_addr)) begin errors++; $display("FAIL contention_addr cycle %0d got %0d", c, write_address); end
      tick();
    end
    idle_inputs();
    settle();
    checks++; if (wb_error !== 1'b0) begin errors++; $display("FAIL contention_wb_error got %b exp 0", wb_error); end
    tick();
  endtask

  task automatic test_raw();
    drive_load(10);
    settle();
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL raw_load_issue got %b exp 0", issue_stall); end
    tick();
    issue_valid = 1'b1; issue_long = 1'b0; issue_rs1 = 5'd10; issue_rs2 = 5'd0; issue_rd = 5'd11;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall cycle %0d got %b exp 1", c, issue_stall); end
      tick();
    end
    lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd10; lsu_wb_data = 32'hCAFE_0010;
    settle();
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_on_wb got %b exp 1", issue_stall); end
    checks++; if (lsu_wb_ready !== 1'b1) begin errors++; $display("FAIL raw_lsu_ready got %b exp 1", lsu_wb_ready); end
    checks++; if (reg_wren !== 1'b1) begin errors++; $display("FAIL raw_wren got %b exp 1", reg_wren); end
    tick();
    lsu_wb_valid = 1'b0;
    settle();
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL raw_unstall got %b exp 0", issue_stall); end
    tick();
    idle_inputs();
  endtask

  task automatic test_capacity();
    for (int r = 16; r < 24; r++) begin
      drive_load(r);
      settle();
      checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL capacity_fill rd %0d got stall %b exp 0", r, issue_stall); end
      tick();
    end
    drive_load(24);
    settle();
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL capacity_ninth got %b exp 1", issue_stall); end
    lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd16;
    settle();
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL capacity_ninth_with_wb got %b exp 1", issue_stall); end
    tick();
    // Seven outstanding: load and writeback together keep the count at seven.
    lsu_wb_addr = 5'd17;
    settle();
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL capacity_simul_issue got %b exp 0", issue_stall); end
    checks++; if (lsu_wb_ready !== 1'b1) begin errors++; $display("FAIL capacity_simul_ready got %b exp 1", lsu_wb_ready); end
    tick();
    lsu_wb_valid = 1'b0;
    drive_load(25);
    settle();
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL capacity_eighth_again got %b exp 0", issue_stall); end
    tick();
    drive_load(26);
    settle();
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL capacity_full_again got %b exp 1", issue_stall); end
    tick();
    idle_inputs();
    lsu_wb_valid = 1'b1;
    for (int r = 18; r <= 25; r++) begin
      lsu_wb_addr = 5'(r);
      tick();
    end
    idle_inputs();
    settle();
    checks++; if (wb_error !== 1'b0) begin errors++; $display("FAIL capacity_wb_error got %b exp 0", wb_error); end
    tick();
  endtask

  task automatic test_x0_error();
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd0; alu_wb_data = 32'hFFFF_FFFF;
    settle();
    checks++; if (alu_wb_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b exp 1", alu_wb_ready); end
    checks++; if (reg_wren !== 1'b0) begin errors++; $display("FAIL x0_wren got %b exp 0", reg_wren); end
    tick();
    idle_inputs();
    lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd7; lsu_wb_data = 32'h7777_7777;
    settle();
    checks++; if (lsu_wb_ready !== 1'b1) begin errors++; $display("FAIL err_lsu_ready got %b exp 1", lsu_wb_ready); end
    checks++; if (wb_error !== 1'b0) begin errors++; $display("FAIL err_same_cycle got %b exp 0", wb_error); end
    tick();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++; if (wb_error !== 1'b1) begin errors++; $display("FAIL err_sticky cycle %0d got %b exp 1", c, wb_error); end
      tick();
    end
    pulse_reset();
    settle();
    checks++; if (wb_error !== 1'b0) begin errors++; $display("FAIL err_cleared_by_reset got %b exp 0", wb_error); end
    tick();
    // A load in flight across reset is forgotten; its writeback is an error.
    drive_load(9);
    tick();
    pulse_reset();
    lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd9;
    settle();
    checks++; if (lsu_wb_ready !== 1'b1) begin errors++; $display("FAIL stale_lsu_ready got %b exp 1", lsu_wb_ready); end
    tick();
    idle_inputs();
    settle();
    checks++; if (wb_error !== 1'b1) begin errors++; $display("FAIL stale_wb_error got %b exp 1", wb_error); end
    tick();
    pulse_reset();
  endtask

  task automatic test_random();
    int idx;
    bit e_alu, e_lsu, e_wren, e_stall;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    out_q.delete();
    starve_m = 0;
    for (int n = 0; n < 600; n++) begin
      alu_wb_valid = ($urandom_range(0, 99) < 55);
      alu_wb_addr  = 5'($urandom_range(0, 31));
      alu_wb_data  = $urandom();
      lsu_wb_valid = (out_q.size() > 0) && ($urandom_range(0, 99) < 45);
      idx = (out_q.size() > 0) ? int'($urandom_range(0, out_q.size() - 1)) : 0;
      lsu_wb_addr  = (out_q.size() > 0) ? 5'(out_q[idx]) : 5'($urandom_range(1, 31));
      lsu_wb_data  = $urandom();
      issue_valid  = ($urandom_range(0, 99) < 70);
      issue_long   = ($urandom_range(0, 99) < 45);
      issue_rs1    = 5'($urandom_range(0, 15));
      issue_rs2    = 5'($urandom_range(0, 15));
      issue_rd     = issue_long ? 5'($urandom_range(1, 15)) : 5'($urandom_range(0, 15));

      e_alu   = alu_wb_valid && (!lsu_wb_valid || starve_m == 4);
      e_lsu   = lsu_wb_valid && !e_alu;
      e_addr  = e_alu ? alu_wb_addr : lsu_wb_addr;
      e_data  = e_alu ? alu_wb_data : lsu_wb_data;
      e_wren  = (e_alu || e_lsu) && (e_addr != 5'd0);
      e_stall = issue_valid && (in_q(int'(issue_rs1)) || in_q(int'(issue_rs2)) || in_q(int'(issue_rd))
                                || (issue_long && out_q.size() == 8));
      settle();
      checks++; if (alu_wb_ready !== e_alu) begin errors++; $display("FAIL rand_alu_ready step %0d got %b exp %b", n, alu_wb_ready, e_alu); end
      checks++; if (lsu_wb_ready !== e_lsu) begin errors++; $display("FAIL rand_lsu_ready step %0d got %b exp %b", n, lsu_wb_ready, e_lsu); end
      checks++; if (reg_wren !== e_wren) begin errors++; $display("FAIL rand_wren step %0d got %b exp %b", n, reg_wren, e_wren); end
      checks++; if (write_address !== e_addr) begin errors++; $display("FAIL rand_addr step %0d got %0d exp %0d", n, write_address, e_addr); end
      checks++; if (write_data !== e_data) begin errors++; $display("FAIL rand_data step %0d got %h exp %h", n, write_data, e_data); end
      checks++; if (issue_stall !== e_stall) begin errors++; $display("FAIL rand_stall step %0d got %b exp %b", n, issue_stall, e_stall); end

      if (e_lsu) out_q.delete(idx);
      if (issue_valid && !e_stall && issue_long) out_q.push_back(int'(issue_rd));
      if (!alu_wb_valid || e_alu) starve_m = 0;
      else if (starve_m < 4) starve_m = starve_m + 1;
      tick();
    end
    idle_inputs();
    settle();
    checks++; if (wb_error !== 1'b0) begin errors++; $display("FAIL rand_wb_error got %b exp 0", wb_error); end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_contention();
    test_raw();
    test_capacity();
    test_x0_error();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
